// File: rtl/serial_operand_adder.sv
// Byte-serial add/subtract unit: operands loaded slice by slice,
// result computed LSB slice first and read back through a select port.
module serial_operand_adder #(
  parameter  int DATA_W = 32,
  parameter  int BYTE_W = 8,
  localparam int NBYTES = DATA_W / BYTE_W,
  localparam int SEL_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] inp,
  input  logic              set_a,
  input  logic              set_b,
  input  logic              clr,
  input  logic              op,
  input  logic              cin,
  input  logic              start,
  input  logic [SEL_W-1:0]  select,
  output logic [BYTE_W-1:0] out,
  output logic              cout,
  output logic              full_a,
  output logic              full_b,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] num_a, num_b, res;
  logic [SEL_W-1:0]  cnt_a, cnt_b, k;
  logic              sa_q, sb_q;
  logic              op_q, carry;
  logic              ld_a, ld_b, go;
  logic [BYTE_W-1:0] a_k, b_k;
  logic [BYTE_W:0]   sum;

  assign ld_a = set_a & ~sa_q & ~full_a & (state != CALC);
  assign ld_b = set_b & ~sb_q & ~full_b & (state != CALC);
  assign go   = start & full_a & full_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go) nxt = CALC;
      CALC:    if (k == LAST) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == FIN);
  end

  // Current slice of each operand and its BYTE_W+1 bit sum
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == i[SEL_W-1:0]) begin
        a_k = num_a[i*BYTE_W +: BYTE_W];
        b_k = num_b[i*BYTE_W +: BYTE_W];
      end
    end
    sum = {1'b0, a_k}
        + {1'b0, (op_q ? ~b_k : b_k)}
        + {{BYTE_W{1'b0}}, carry};
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (select == i[SEL_W-1:0])
        out = res[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_a  <= '0;
      num_b  <= '0;
      res    <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      k      <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      full_a <= 1'b0;
      full_b <= 1'b0;
      op_q   <= 1'b0;
      carry  <= 1'b0;
      cout   <= 1'b0;
    end else begin
      sa_q <= set_a;
      sb_q <= set_b;
      if (clr) begin
        cnt_a  <= '0;
        cnt_b  <= '0;
        full_a <= 1'b0;
        full_b <= 1'b0;
      end else begin
        if (ld_a) begin
          for (int i = 0; i < NBYTES; i++)
            if (cnt_a == i[SEL_W-1:0])
              num_a[i*BYTE_W +: BYTE_W] <= inp;
          if (cnt_a == LAST) begin
            full_a <= 1'b1;
            cnt_a  <= '0;
          end else begin
            cnt_a <= cnt_a + 1'b1;
          end
        end
        if (ld_b) begin
          for (int i = 0; i < NBYTES; i++)
            if (cnt_b == i[SEL_W-1:0])
              num_b[i*BYTE_W +: BYTE_W] <= inp;
          if (cnt_b == LAST) begin
            full_b <= 1'b1;
            cnt_b  <= '0;
          end else begin
            cnt_b <= cnt_b + 1'b1;
          end
        end
        if (state == IDLE && go) begin
          op_q  <= op;
          k     <= '0;
          carry <= op | cin;
        end
        if (state == CALC) begin
          for (int i = 0; i < NBYTES; i++)
            if (k == i[SEL_W-1:0])
              res[i*BYTE_W +: BYTE_W] <= sum[BYTE_W-1:0];
          carry <= sum[BYTE_W];
          k     <= k + 1'b1;
          // Operands are consumed: flags drop so the next load can begin
          if (k == LAST) begin
            cout   <= sum[BYTE_W];
            full_a <= 1'b0;
            full_b <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_adder.sv
// Bench for serial_operand_adder: directed and random add/sub runs
// checked against a whole-word arithmetic model.
module tb_serial_operand_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inp = '0;
  logic       set_a = 1'b0;
  logic       set_b = 1'b0;
  logic       clr = 1'b0;
  logic       op = 1'b0;
  logic       cin = 1'b0;
  logic       start = 1'b0;
  logic [1:0] select = '0;
  logic [7:0] out;
  logic       cout, full_a, full_b, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_operand_adder #(.DATA_W(32), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .set_a(set_a), .set_b(set_b), .clr(clr),
    .op(op), .cin(cin), .start(start),
    .select(select), .out(out), .cout(cout),
    .full_a(full_a), .full_b(full_b),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic o, input logic c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (o) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic pulse(input logic wa, input logic wb,
                       input logic [7:0] v);
    @(negedge clk);
    inp = v; set_a = wa; set_b = wb;
    @(negedge clk);
    set_a = 1'b0; set_b = 1'b0;
  endtask

  task automatic load(input logic wa, input logic wb,
                      input logic [31:0] v);
    for (int i = 0; i < 4; i++) pulse(wa, wb, v[i*8 +: 8]);
  endtask

  task automatic read_res(output logic [31:0] r);
    for (int s = 0; s < 4; s++) begin
      select = s[1:0];
      #1;
      r[s*8 +: 8] = out;
    end
  endtask

  // Start a compute on loaded operands, poke inputs mid-flight,
  // then check timing, result and carry.
  task automatic compute(input string tag, input logic o,
                         input logic c, input logic [32:0] exp);
    logic [31:0] r;
    @(negedge clk);
    op = o; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_nodone"}, done, 1'b0);
      op = $urandom; cin = $urandom; inp = $urandom;
      set_a = (j == 1); set_b = (j == 1);
      @(negedge clk);
    end
    set_a = 1'b0; set_b = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_fulls"}, {full_a, full_b}, 2'b00);
    read_res(r);
    chk({tag, "_result"}, r, exp[31:0]);
    chk({tag, "_cout"}, cout, exp[32]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run(input string tag, input logic o, input logic c,
                     input logic [31:0] a, input logic [31:0] b);
    load(1'b1, 1'b0, a);
    load(1'b0, 1'b1, b);
    compute(tag, o, c, model(o, c, a, b));
  endtask

  initial begin
    logic [31:0] r, ra, rb, v;
    logic        ro, rc;

    repeat (3) @(negedge clk);
    read_res(r);
    chk("rst_out", r, 32'h0);
    chk("rst_flags", {cout, full_a, full_b, busy, done}, 5'b0);
    rst = 1'b0;

    run("basic", 1'b0, 1'b0, 32'h01020304, 32'h000000FF);
    run("wrap", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    run("cin", 1'b0, 1'b1, 32'h0, 32'h0);
    run("sub_neg", 1'b1, 1'b1, 32'h00000005, 32'h00000007);
    run("sub_pos", 1'b1, 1'b0, 32'h00000007, 32'h00000005);

    // A strobe held high loads one slice only
    @(negedge clk);
    inp = 8'h11; set_a = 1'b1;
    repeat (6) @(negedge clk);
    set_a = 1'b0;
    chk("hold_notfull", full_a, 1'b0);
    pulse(1'b1, 1'b0, 8'h22);
    pulse(1'b1, 1'b0, 8'h33);
    chk("hold_3slices", full_a, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("partial_start", busy, 1'b0);
    pulse(1'b1, 1'b0, 8'h44);
    chk("hold_full", full_a, 1'b1);
    load(1'b0, 1'b1, 32'h00000001);
    compute("hold_run", 1'b0, 1'b0,
            model(1'b0, 1'b0, 32'h44332211, 32'h1));

    // Strobes during the last compute must not have advanced cntA
    pulse(1'b1, 1'b0, 8'h01);
    pulse(1'b1, 1'b0, 8'h02);
    pulse(1'b1, 1'b0, 8'h03);
    chk("calc_strobe_ign", full_a, 1'b0);
    pulse(1'b1, 1'b0, 8'h04);
    chk("calc_strobe_full", full_a, 1'b1);

    // Joint load of both operands, then an extra A strobe is ignored
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_flags", {full_a, full_b}, 2'b00);
    load(1'b1, 1'b1, 32'h1234ABCD);
    chk("joint_full", {full_a, full_b}, 2'b11);
    pulse(1'b1, 1'b0, 8'hEE);
    compute("joint_run", 1'b0, 1'b0,
            model(1'b0, 1'b0, 32'h1234ABCD, 32'h1234ABCD));

    for (int n = 0; n < 8; n++) begin
      ra = $urandom; rb = $urandom;
      ro = $urandom; rc = $urandom;
      if (n == 0) rb = ra;
      run($sformatf("rnd%0d", n), ro, rc, ra, rb);
    end

    // Async reset in the middle of a compute
    load(1'b1, 1'b0, 32'hDEADBEEF);
    load(1'b0, 1'b1, 32'h01010101);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    read_res(r);
    chk("rst_mid_out", r, 32'h0);
    chk("rst_mid_flags", {cout, full_a, full_b, busy, done}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("rst_mid_nodone", done, 1'b0);
      @(negedge clk);
    end

    // Synchronous clear aborting a compute
    load(1'b1, 1'b0, 32'h00000010);
    load(1'b0, 1'b1, 32'h00000020);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_mid_state", {busy, done, full_a, full_b}, 4'b0);
    for (int j = 0; j < 5; j++) begin
      chk("clr_mid_nodone", done, 1'b0);
      @(negedge clk);
    end

    // clr wins over start in the same cycle
    load(1'b1, 1'b1, 32'h0F0F0F0F);
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_start", {busy, full_a, full_b}, 3'b000);
    @(negedge clk);
    chk("clr_start_idle", busy, 1'b0);

    v = 32'h0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_operand_adder.md
Name: serial_operand_adder

Overview:
Parametrised, clocked successor to the byte-loaded 32-bit adder controller. Two operands are loaded one BYTE_W slice at a time from a narrow input bus. The sum or difference is computed byte-serially, LSB slice first, through a registered carry. The result is read back one slice at a time through a select port. It sits between the switch/button front end and the display path, so operand width can grow without widening the pins.

Parameters:
DATA_W, 32, operand/result width in bits; must be an integer multiple of BYTE_W.
BYTE_W, 8, width of the input bus, the output bus and one compute slice.
NBYTES (local), DATA_W/BYTE_W, number of slices per operand.
SEL_W (local), max(1, clog2(NBYTES)), width of the select port.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
inp  in  BYTE_W  operand slice to load
set_a  in  1  load strobe for operand A (level input, rising edge detected internally)
set_b  in  1  load strobe for operand B (level input, rising edge detected internally)
clr  in  1  synchronous clear of load counters, full flags and FSM
op  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
cin  in  1  carry in for add
start  in  1  compute request, sampled in IDLE only
select  in  SEL_W  result slice to drive on out
out  out  BYTE_W  result[select*BYTE_W +: BYTE_W]; 0 if select >= NBYTES
cout  out  1  final carry; for subtract, 1 = no borrow
full_a  out  1  all NBYTES slices of A loaded
full_b  out  1  all NBYTES slices of B loaded
busy  out  1  high while in CALC
done  out  1  one-cycle pulse when the result is complete

Behaviour:
- Reset (async, immediate): numA, numB, result = 0. Counters = 0. full_a = full_b = 0. cout = 0. busy = done = 0. FSM = IDLE. Edge-detect registers = 0.
- Edge detect: a load occurs on a cycle where set_x = 1 and set_x was 0 on the previous clk.
  - Holding the strobe high loads exactly one slice.
- Load A (IDLE or DONE, full_a = 0): numA[cntA*BYTE_W +: BYTE_W] <= inp; cntA++.
  - When cntA reaches NBYTES-1 and loads, full_a <= 1 and cntA <= 0 (wrap).
  - Strobes while full_a = 1 or in CALC are ignored. B loads identically.
- Simultaneous set_a and set_b edges: both operands load the same inp slice in the same cycle.
- clr (any state, lower priority than rst): counters = 0, full flags = 0, FSM -> IDLE, done = 0. Aborts CALC with no done pulse. numA, numB, result and cout are unchanged.
- IDLE: if start = 1, full_a = 1 and full_b = 1, go to CALC.
  - Latch op; k = 0; carry = op ? 1 : cin.
  - Otherwise start is ignored.
- CALC, one slice per cycle, for k = 0..NBYTES-1:
  - {c, s} = A_k + (op ? ~B_k : B_k) + carry, computed at BYTE_W+1 bits.
  - result_k <= s; carry <= c.
  - On the final slice, cout <= c and go to DONE. busy = 1 throughout CALC.
- DONE, one cycle: done = 1, busy = 0. full_a and full_b are cleared, counters are 0, and operands are retained. Next state is IDLE.
  - Loads are accepted in this cycle.
  - start in DONE is ignored.
- Latency: start sampled at edge t. CALC occupies cycles t+1 .. t+NBYTES. done is high in cycle t+NBYTES+1. result and cout are final from that cycle onward.
- op, cin and inp changes during CALC do not affect the operation in flight.
- out is combinational from the result register and select, and is valid in every state. During CALC the slices already computed show new values and the rest show old values.
- clr and start in the same cycle: clr wins and no compute starts.

Test Plan:
- Reset, then check all outputs: out = 0, cout = 0, full_a = full_b = busy = done = 0.
- Load A = 0x01020304 (slices 04,03,02,01) and B = 0x000000FF (FF,00,00,00). Assert start with op=0, cin=0.
  - busy for 4 cycles; done in cycle t+5.
  - select 0..3 reads 03,04,02,01, i.e. result 0x01020403; cout = 0.
- Load A = 0xFFFFFFFF, B = 0x00000001, op=0, cin=0 -> result 0x00000000, cout = 1.
  - Repeat with A = B = 0, cin = 1 -> result 0x00000001, cout = 0.
- Load A = 0x00000005, B = 0x00000007, op=1, cin=1 -> result 0xFFFFFFFE, cout = 0 (cin ignored).
  - Swap the operands -> result 0x00000002, cout = 1.
- Hold set_a high for 6 cycles -> one slice loaded, cntA = 1.
  - Assert start with A partial -> no busy.
  - Assert set_a and set_b in the same cycle -> both load inp.
  - Assert a 5th set_a after full_a -> ignored.
  - Assert set_a during CALC -> ignored.
- Assert rst mid-CALC (cycle 2) -> all outputs 0 immediately, no done.
  - Assert clr mid-CALC -> FSM returns to IDLE, no done, full flags 0.
